// File: rtl/clk_division_multi.sv
// NUM_CH-channel programmable clock divider with glitch-free divisor reload and per-channel tick strobes.
// Optional build macro CLKDIV_SYNC_EN adds sync_req to phase-align all enabled channels.

module clk_division_ch #(
   parameter int                CNT_W       = 32,
   parameter logic [CNT_W-1:0]  DEFAULT_DIV = '0
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             wr_hit,
   input  logic [CNT_W-1:0] wr_data,
`ifdef CLKDIV_SYNC_EN
   input  logic             sync_req,
`endif
   output logic             divclk,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] active_div;
   logic [CNT_W-1:0] shadow_div;
   logic [CNT_W-1:0] shadow_nxt;

   // A write landing on the terminal cycle must be seen by that reload.
   assign shadow_nxt = wr_hit ? wr_data : shadow_div;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         divclk     <= 1'b0;
         tick       <= 1'b0;
         active_div <= DEFAULT_DIV;
         shadow_div <= DEFAULT_DIV;
      end else begin
         shadow_div <= shadow_nxt;
         if (!en) begin
            cnt        <= '0;
            divclk     <= 1'b0;
            tick       <= 1'b0;
            active_div <= shadow_nxt;
`ifdef CLKDIV_SYNC_EN
         end else if (sync_req) begin
            // Realign wins over reload; a same-cycle write waits for the next terminal count.
            cnt        <= '0;
            divclk     <= 1'b0;
            tick       <= 1'b0;
            active_div <= shadow_div;
`endif
         end else if (cnt == active_div) begin
            cnt        <= '0;
            divclk     <= ~divclk;
            tick       <= 1'b1;
            active_div <= shadow_nxt;
         end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
         end
      end
   end

endmodule

module clk_division_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = 24999,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              div_wr,
   input  logic [CH_W-1:0]   div_wr_ch,
   input  logic [CNT_W-1:0]  div_wr_data,
`ifdef CLKDIV_SYNC_EN
   input  logic              sync_req,
`endif
   output logic [NUM_CH-1:0] divclk,
   output logic [NUM_CH-1:0] tick
);

   // Out-of-range channel indices simply match no lane.
   logic [NUM_CH-1:0] wr_hit;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_hit[i] = div_wr && (div_wr_ch == CH_W'(i));

      clk_division_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
      ) u_ch (
         .clk_in   (clk_in),
         .rst      (rst),
         .en       (ch_en[i]),
         .wr_hit   (wr_hit[i]),
         .wr_data  (div_wr_data),
`ifdef CLKDIV_SYNC_EN
         .sync_req (sync_req),
`endif
         .divclk   (divclk[i]),
         .tick     (tick[i])
      );
   end

endmodule
